sram22_req_adapter: RTL
=======================

SRAM22_REQ_ADAPTER -- requirements
Module: sram22_req_adapter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, word address width; DATA_WIDTH, default 64, data width; WMASK_WIDTH, default 8, byte-lane mask width (DATA_WIDTH/WMASK_WIDTH bits per lane); RSP_DEPTH, default 2, response buffer depth (minimum 2).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock.
- rstb  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = write, 0 = read.
- req_wmask  in  WMASK_WIDTH  byte-lane write enables.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_rdata.
- rsp_rdata  out  DATA_WIDTH  read data.
- sram_ce, sram_we  out  1 each  macro chip enable and write enable.
- sram_wmask  out  WMASK_WIDTH  macro write mask.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_din  out  DATA_WIDTH  macro write data.
- sram_dout  in  DATA_WIDTH  macro registered read data.
- sram_rstb  out  1  macro reset, driven as rstb.
- rd_count, wr_count  out  16 each  accepted-read and accepted-write counters.

Function
REQ-003 Accept = req_valid && req_ready; the adapter SHALL drive sram_ce = accept, sram_we = req_we, and pass sram_wmask, sram_addr and sram_din through combinationally from the request.
REQ-004 When accept is low, sram_we and sram_wmask SHALL be 0.
REQ-005 Occupancy (buffered responses, 0..RSP_DEPTH) plus inflight (read issued in the previous cycle, 0..1) SHALL gate acceptance: req_ready = rstb && (occupancy + inflight < RSP_DEPTH), for reads and writes alike.
REQ-006 A read accepted in cycle N SHALL set inflight for cycle N+1, in which sram_dout holds the read data.
REQ-007 In cycle N+1, if the buffer is empty, sram_dout SHALL bypass to rsp_rdata with rsp_valid=1. If rsp_ready is also 1, nothing is stored; otherwise sram_dout is pushed into the buffer at the end of N+1.
REQ-008 In cycle N+1, if the buffer is non-empty, rsp_rdata SHALL present the buffer head and sram_dout SHALL be pushed at the end of N+1.
REQ-009 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-010 Responses SHALL return in request order.
REQ-011 Writes SHALL produce no response.
REQ-012 The credit rule SHALL make buffer overflow impossible.
REQ-013 With rsp_ready held 1, the adapter SHALL sustain one accepted request per cycle, with read latency exactly 1 cycle.
REQ-014 rsp_valid and rsp_rdata SHALL remain stable while rsp_valid && !rsp_ready.
REQ-015 rd_count and wr_count SHALL increment on each accepted read or write respectively, and wrap from 0xFFFF to 0.

Reset
REQ-016 On rstb low (asynchronous), the block SHALL immediately clear occupancy, inflight, the buffer pointers and both counters.
REQ-017 Reset values SHALL be: rsp_valid=0, rsp_rdata=0, req_ready=0, sram_ce=0, sram_we=0, sram_wmask=0.
REQ-018 A read in flight when reset asserts SHALL be discarded and never presented after reset.
REQ-019 Reset release SHALL be synchronised externally; the first accept is permitted in the first cycle after rstb rises.

Structure
REQ-020 Package sram22_pkg SHALL hold the default width constants and the request and response struct typedefs.
REQ-021 The response buffer SHALL be sub-module sram22_rsp_fifo: RSP_DEPTH entries, wrap-around pointers, push, pop, occupancy output, and combinational head output.
REQ-022 The SRAM macro SHALL be instantiated by the parent, not by this block.

Verification
REQ-023 Write then read: write addr 0x005, data 0x0123456789ABCDEF, wmask 0xFF; read addr 0x005 -> rsp_valid exactly one cycle after the read accept, rsp_rdata=0x0123456789ABCDEF.
REQ-024 Byte mask: write 0xFFFFFFFFFFFFFFFF to addr 0x3FF; write 0x0 with wmask 0x0F; read addr 0x3FF -> 0xFFFFFFFF00000000.
REQ-025 Backpressure: rsp_ready=0, issue 3 reads -> req_ready drops after 2 accepts; rsp_ready=1 -> data returns in order, and the third read is accepted when credit frees.
REQ-026 Streaming: 16 back-to-back reads with rsp_ready=1 -> req_ready never drops; 16 responses in order; rd_count=16.
REQ-027 Reset mid-operation: rstb low in the cycle after a read accept -> rsp_valid=0 immediately; after release, no stale response appears and rd_count=0.

Source files
------------

// File: rtl/sram22_pkg.sv
// Shared constants and transaction types for the SRAM22 request adapter.
package sram22_pkg;

  localparam int SRAM22_ADDR_WIDTH  = 10;
  localparam int SRAM22_DATA_WIDTH  = 64;
  localparam int SRAM22_WMASK_WIDTH = 8;
  localparam int SRAM22_RSP_DEPTH   = 2;

  // Request as offered on the req_* channel (default widths).
  typedef struct packed {
    logic                          we;
    logic [SRAM22_WMASK_WIDTH-1:0] wmask;
    logic [SRAM22_ADDR_WIDTH-1:0]  addr;
    logic [SRAM22_DATA_WIDTH-1:0]  wdata;
  } sram22_req_t;

  // Response as presented on the rsp_* channel (default widths).
  typedef struct packed {
    logic [SRAM22_DATA_WIDTH-1:0] rdata;
  } sram22_rsp_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Small response buffer: wrap-around pointers, occupancy count and a
// combinational head so the oldest entry is visible without a pop.
module sram22_rsp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= f_next(r_wr_ptr);
      if (pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array written on push.
  always_ff @(posedge clk) begin
    // NOTE: the data array is not reset; validity is tracked by the pointers and count alone.
    if (push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/sram22_req_adapter.sv
// Valid/ready front end for an SRAM22 macro with a registered read port.
// Read data either bypasses straight to the response port or is parked in
// a small buffer; a credit check on buffer space plus the in-flight read
// gates request acceptance so the buffer can never overflow.
module sram22_req_adapter
  import sram22_pkg::*;
#(
  parameter int ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
  parameter int DATA_WIDTH  = SRAM22_DATA_WIDTH,
  parameter int WMASK_WIDTH = SRAM22_WMASK_WIDTH,
  parameter int RSP_DEPTH   = SRAM22_RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   sram_rstb,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0] LP_DEPTH = (CNT_W + 1)'(RSP_DEPTH);

  logic                  r_inflight;
  logic [15:0]           r_rd_count;
  logic [15:0]           r_wr_count;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_wr_accept;
  logic [CNT_W-1:0]      w_occ;
  logic [CNT_W:0]        w_credit_used;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head;

  // Credit check: buffered responses plus the read whose data arrives next cycle.
  assign w_credit_used = {1'b0, w_occ} + {{CNT_W{1'b0}}, r_inflight};
  assign req_ready     = rstb && (w_credit_used < LP_DEPTH);

  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_we;
  assign w_wr_accept = w_accept && req_we;

  // Macro drive: addr/data pass through, strobes qualified by the handshake.
  assign sram_ce    = w_accept;
  assign sram_we    = w_wr_accept;
  assign sram_wmask = w_accept ? req_wmask : '0;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;
  assign sram_rstb  = rstb;

  // Returning read data is parked unless it bypasses straight to a ready consumer.
  assign w_empty   = (w_occ == '0);
  assign w_push    = r_inflight && !(w_empty && rsp_ready);
  assign w_pop     = !w_empty && rsp_ready;
  assign rsp_valid = r_inflight || !w_empty;

  // Response data: buffer head has priority so ordering is preserved.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    rsp_rdata = '0;
    if (!w_empty)        rsp_rdata = w_head;
    else if (r_inflight) rsp_rdata = sram_dout;
  end

  // In-flight flag and accepted-request counters (counters wrap naturally).
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_inflight <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_inflight <= w_rd_accept;
      if (w_rd_accept) r_rd_count <= r_rd_count + 16'd1;
      if (w_wr_accept) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  sram22_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (w_push),
    .din   (sram_dout),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_occ)
  );

endmodule
